// File: rtl/cbus_arbiter_pkg.sv
// Shared cbus types: request/response structs plus burst length, size and burst-type encodings.
// No logic; types only.
// MLEN encodes beats-1 so a 4-bit field covers 1..16 beats.
package cbus_arbiter_pkg;

  typedef enum logic [3:0] {
    MLEN1  = 4'd0,
    MLEN2  = 4'd1,
    MLEN4  = 4'd3,
    MLEN8  = 4'd7,
    MLEN16 = 4'd15
  } mlen_t;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2
  } msize_t;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'd0,
    AXI_BURST_INCR  = 2'd1,
    AXI_BURST_WRAP  = 2'd2
  } axi_burst_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [31:0] addr;
    msize_t      size;
    mlen_t       len;
    axi_burst_t  burst;
    logic [3:0]  strobe;
    logic [31:0] data;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

  // Number of beats a burst of the given length code carries.
  function automatic logic [4:0] mlen_beats(input mlen_t len);
    return {1'b0, len} + 5'd1;
  endfunction

endpackage

// File: rtl/cbus_arbiter_rr_picker.sv
// Round-robin picker: first valid requester after last_grant, wrapping modulo NUM_REQ.
// Purely combinational, zero latency.
// No handshake; any_valid low means winner is meaningless (driven 0).
module rr_picker #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         valid,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic                       any_valid
);

  localparam int IDW = $clog2(NUM_REQ);

  // Scan from the farthest candidate to the nearest so the nearest valid one wins.
  always_comb begin
    logic [IDW-1:0] idx;
    winner    = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IDW'((int'(last_grant) + k) % NUM_REQ);
      if (valid[idx]) begin
        winner    = idx;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cbus_arbiter.sv
// Arbitrates NUM_REQ cache requesters onto one memory-side cbus, one burst at a time.
// Grant latency 2 cycles (IDLE->GRANT->BUSY); forwarding in BUSY is combinational both ways.
// oresp.ready paces beats; requester dropping valid mid-burst aborts with sticky err.
module cbus_arbiter
  import cbus_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int MAX_BEATS = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  cbus_req_t                  ireqs  [NUM_REQ],
  output cbus_resp_t                 iresps [NUM_REQ],
  output cbus_req_t                  oreq,
  input  cbus_resp_t                 oresp,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       err
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] sel, sel_nxt;
  logic [IDW-1:0] last_grant, last_grant_nxt;
  logic [CW-1:0]  beat_cnt, beat_cnt_nxt;
  logic           err_flag, err_nxt;

  logic [NUM_REQ-1:0] req_valid;
  logic [IDW-1:0]     rr_winner;
  logic               rr_any;
  cbus_req_t          sel_req;

  // Collect the valid bits for the picker.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i] = ireqs[i].valid;
    end
  end

  assign sel_req = ireqs[sel];

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_picker (
    .valid      (req_valid),
    .last_grant (last_grant),
    .winner     (rr_winner),
    .any_valid  (rr_any)
  );

  // State register; last_grant resets to the top index so requester 0 wins first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      sel        <= '0;
      last_grant <= IDW'(NUM_REQ - 1);
      beat_cnt   <= '0;
      err_flag   <= 1'b0;
    end else begin
      state      <= state_nxt;
      sel        <= sel_nxt;
      last_grant <= last_grant_nxt;
      beat_cnt   <= beat_cnt_nxt;
      err_flag   <= err_nxt;
    end
  end

  // Next-state logic: winner latched only on IDLE->GRANT, burst ends on last or valid drop.
  always_comb begin
    state_nxt      = state;
    sel_nxt        = sel;
    last_grant_nxt = last_grant;
    beat_cnt_nxt   = beat_cnt;
    err_nxt        = err_flag;
    case (state)
      IDLE: begin
        if (rr_any) begin
          sel_nxt   = rr_winner;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        beat_cnt_nxt = '0;
        state_nxt    = BUSY;
      end
      BUSY: begin
        if (oresp.ready && (beat_cnt != CW'(MAX_BEATS))) begin
          beat_cnt_nxt = beat_cnt + 1'b1;
        end
        if (!sel_req.valid) begin
          // Owner abandoned the burst before its last beat.
          err_nxt        = 1'b1;
          state_nxt      = IDLE;
          last_grant_nxt = sel;
        end else if (oresp.ready) begin
          if (oresp.last) begin
            state_nxt      = IDLE;
            last_grant_nxt = sel;
          end else if (beat_cnt == CW'(MAX_BEATS - 1)) begin
            // This beat is number MAX_BEATS and still not last: overlong burst.
            err_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output muxing: only the owner sees the bus, and only while BUSY.
  always_comb begin
    oreq = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      iresps[i] = '0;
    end
    if (state == BUSY) begin
      oreq        = sel_req;
      iresps[sel] = oresp;
    end
  end

  // Status outputs; grant_id is forced to 0 while reset is held.
  always_comb begin
    busy     = (state == BUSY);
    err      = err_flag;
    grant_id = '0;
    if (reset) begin
      grant_id = (state == IDLE) ? last_grant : sel;
    end
  end

endmodule

// File: tb/tb_cbus_arbiter.sv
`timescale 1ns/1ps
module tb_cbus_arbiter;
  import cbus_arbiter_pkg::*;

  localparam int NUM_REQ   = 2;
  localparam int MAX_BEATS = 16;
  localparam cbus_resp_t JUNK = '{ready: 1'b1, last: 1'b1, data: 32'hDEAD_BEEF};

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  cbus_req_t  ireqs  [NUM_REQ];
  cbus_resp_t iresps [NUM_REQ];
  cbus_req_t  oreq;
  cbus_resp_t oresp;
  logic [0:0] grant_id;
  logic       busy;
  logic       err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          id;
    logic [31:0] data;
    logic        last;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  cbus_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .MAX_BEATS (MAX_BEATS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ireqs    (ireqs),
    .iresps   (iresps),
    .oreq     (oreq),
    .oresp    (oresp),
    .grant_id (grant_id),
    .busy     (busy),
    .err      (err)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic cbus_req_t mk(input logic wr, input logic [31:0] addr, input mlen_t len,
                                   input msize_t size, input logic [3:0] strobe);
    cbus_req_t r;
    r          = '0;
    r.valid    = 1'b1;
    r.is_write = wr;
    r.addr     = addr;
    r.size     = size;
    r.len      = len;
    r.burst    = AXI_BURST_INCR;
    r.strobe   = strobe;
    r.data     = wr ? 32'hCAFE_0001 : 32'h0;
    return r;
  endfunction

  // Monitor: each negedge pops at most one expected beat and checks every iresps lane.
  initial begin
    bit         have;
    exp_t       e;
    cbus_resp_t exp_r;
    forever begin
      @(negedge clk);
      have = (sb.size() > 0);
      if (have) e = sb.pop_front();
      for (int i = 0; i < NUM_REQ; i++) begin
        exp_r = '0;
        if (have && e.id == i) exp_r = '{ready: 1'b1, last: e.last, data: e.data};
        checks++;
        if (iresps[i] !== exp_r) begin
          errors++;
          $display("FAIL iresps[%0d]: got 0x%0h, required 0x%0h", i, iresps[i], exp_r);
        end
      end
    end
  end

  // Memory-side responder for one transaction; expected beats go to the scoreboard.
  task automatic serve(input int id, input int nbeats, input logic [31:0] base,
                       input int drop_at, input int exp_lat, input bit release_req);
    int n;
    bit found;
    n     = 0;
    found = 1'b0;
    oresp = JUNK;
    while (!found && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (oreq.valid) found = 1'b1;
      else check("oreq_zero_before_busy", oreq, 128'h0);
    end
    if (!found) begin
      check("grant_timeout", 0, 1);
      oresp = '0;
      return;
    end
    if (exp_lat >= 0) check("grant_latency", n, exp_lat);
    check("grant_id", grant_id, id);
    check("oreq_fwd", oreq, ireqs[id]);
    check("busy_on", busy, 1);
    for (int b = 0; b < nbeats; b++) begin
      if (b == drop_at) break;
      oresp = '{ready: 1'b1, last: (b == nbeats - 1), data: base + 32'(b)};
      sb.push_back('{id: id, data: base + 32'(b), last: (b == nbeats - 1)});
      @(posedge clk); #1;
    end
    oresp = '0;
    if (drop_at >= 0 && drop_at < nbeats) begin
      check("err_before_drop", err, 0);
      ireqs[id].valid = 1'b0;
      @(posedge clk); #1;
      check("err_after_drop", err, 1);
      check("busy_after_drop", busy, 0);
    end else begin
      if (release_req) ireqs[id].valid = 1'b0;
      check("busy_off_after_last", busy, 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NUM_REQ; i++) ireqs[i] = '0;
    oresp = '0;

    // Reset state
    #23;
    check("rst_oreq", oreq, 128'h0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_grant_id", grant_id, 0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("idle_grant_id", grant_id, NUM_REQ - 1);

    // Both requesters at once after reset: 0 then 1
    ireqs[0] = mk(1'b0, 32'h0000_0100, MLEN4, MSIZE4, 4'hF);
    ireqs[1] = mk(1'b0, 32'h0000_0200, MLEN2, MSIZE4, 4'hF);
    serve(0, 4, 32'h0000_0A00, -1, 2, 1'b1);
    serve(1, 2, 32'h0000_0B00, -1, 2, 1'b1);

    // Single ICache 16-beat read
    ireqs[0] = mk(1'b0, 32'h0000_1000, MLEN16, MSIZE4, 4'hF);
    serve(0, 16, 32'h0000_1000, -1, 2, 1'b1);
    check("err_after_16_beats", err, 0);

    // DCache uncached single-beat write
    ireqs[1] = mk(1'b1, 32'h0000_8004, MLEN1, MSIZE4, 4'h0F);
    serve(1, 1, 32'h0000_0C00, -1, 2, 1'b1);
    check("wr_state_idle", grant_id, 1);

    // Requester 1 holds valid while 0 issues 3 back-to-back: 0,1,0,1,0
    ireqs[0] = mk(1'b0, 32'h0000_2000, MLEN2, MSIZE4, 4'hF);
    ireqs[1] = mk(1'b0, 32'h0000_3000, MLEN1, MSIZE4, 4'hF);
    serve(0, 2, 32'h0000_2000, -1, 2, 1'b0);
    serve(1, 1, 32'h0000_3000, -1, 2, 1'b0);
    serve(0, 2, 32'h0000_2100, -1, 2, 1'b0);
    serve(1, 1, 32'h0000_3100, -1, 2, 1'b1);
    serve(0, 2, 32'h0000_2200, -1, 2, 1'b1);
    check("err_after_alternate", err, 0);

    // Overlong burst: 17 beats, last only on the 17th
    ireqs[0] = mk(1'b0, 32'h0000_4000, MLEN16, MSIZE4, 4'hF);
    serve(0, 17, 32'h0000_4000, -1, 2, 1'b1);
    check("err_overlong", err, 1);

    // Reset pulse clears err
    #2 reset = 1'b0;
    #1 check("rst_pulse_err", err, 0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // Valid dropped after beat 5 of 16; err sticks through a good transaction
    ireqs[0] = mk(1'b0, 32'h0000_5000, MLEN16, MSIZE4, 4'hF);
    serve(0, 16, 32'h0000_5000, 5, 2, 1'b1);
    ireqs[1] = mk(1'b0, 32'h0000_6000, MLEN1, MSIZE4, 4'hF);
    serve(1, 1, 32'h0000_6000, -1, 2, 1'b1);
    check("err_sticky", err, 1);

    // Reset asserted during beat 8 with no clock edge
    ireqs[0] = mk(1'b0, 32'h0000_9000, MLEN16, MSIZE4, 4'hF);
    for (int k = 0; k < 20 && !oreq.valid; k++) begin
      @(posedge clk); #1;
    end
    check("rst_burst_started", oreq.valid, 1);
    for (int b = 0; b < 7; b++) begin
      oresp = '{ready: 1'b1, last: 1'b0, data: 32'h0000_9000 + 32'(b)};
      sb.push_back('{id: 0, data: 32'h0000_9000 + 32'(b), last: 1'b0});
      @(posedge clk); #1;
    end
    oresp = '{ready: 1'b1, last: 1'b0, data: 32'h0000_9007};
    #2 reset = 1'b0;
    #1;
    check("midrst_oreq_valid", oreq.valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_err", err, 0);
    check("midrst_iresp0", iresps[0], 128'h0);
    oresp           = '0;
    ireqs[0].valid  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("post_rst_grant_id", grant_id, NUM_REQ - 1);
    ireqs[0] = mk(1'b0, 32'h0000_7000, MLEN1, MSIZE4, 4'hF);
    ireqs[1] = mk(1'b0, 32'h0000_7100, MLEN1, MSIZE4, 4'hF);
    serve(0, 1, 32'h0000_7000, -1, 2, 1'b1);
    serve(1, 1, 32'h0000_7100, -1, 2, 1'b1);

    @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
